// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, start-bit glitch rejection, LSB-first data,
// configurable stop length, registered done/framing-error pulses.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_TICKS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_s_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int unsigned STOP_W = $clog2(STOP_TICKS);
    localparam int unsigned SCNT_W = (STOP_W > 4) ? STOP_W : 4;
    localparam int unsigned NCNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic [SCNT_W-1:0]      s_cnt_q;
    logic [NCNT_W-1:0]      n_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;

    assign rx_s = sync_q[1];

    // Synchronizer, frame FSM and registered outputs in one clocked process
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            shift_q     <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], i_rx};
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_cnt_q <= '0;
                    end
                end
                START: begin
                    if (i_s_tick) begin
                        if (s_cnt_q == SCNT_W'(7)) begin
                            // Mid start bit: a high line here means it was a glitch
                            s_cnt_q <= '0;
                            n_cnt_q <= '0;
                            state_q <= rx_s ? IDLE : DATA;
                        end else begin
                            s_cnt_q <= s_cnt_q + SCNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (i_s_tick) begin
                        if (s_cnt_q == SCNT_W'(15)) begin
                            s_cnt_q <= '0;
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            if (n_cnt_q == NCNT_W'(DATA_BITS - 1)) begin
                                state_q <= STOP;
                            end else begin
                                n_cnt_q <= n_cnt_q + NCNT_W'(1);
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + SCNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (i_s_tick) begin
                        if (s_cnt_q == SCNT_W'(STOP_TICKS - 1)) begin
                            s_cnt_q     <= '0;
                            state_q     <= IDLE;
                            o_data      <= shift_q;
                            o_rx_done   <= 1'b1;
                            o_frame_err <= ~rx_s;
                        end else begin
                            s_cnt_q <= s_cnt_q + SCNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames scored against
// a frame-level model (expected word = byte sent, error = stop bit low).
module tb_uart_rx;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_TICKS = 16;
    localparam int unsigned TICK_DIV   = 4;

    logic                 clk = 1'b0;
    logic                 i_reset;
    logic                 i_s_tick;
    logic                 i_rx;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_rx_done;
    logic                 o_frame_err;

    int                   total = 0;
    int                   bad   = 0;
    bit                   tick_en = 1'b1;
    logic [8:0]           got_q[$];
    logic [8:0]           exp_q[$];
    logic [7:0]           mon_data;
    logic                 prev_done;

    always #10 clk = ~clk;

    uart_rx #(
        .DATA_BITS  (DATA_BITS),
        .STOP_TICKS (STOP_TICKS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_s_tick    (i_s_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Oversample tick: one-cycle pulse every TICK_DIV clocks while enabled
    initial begin
        int cnt;
        cnt      = 0;
        i_s_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                cnt      = (cnt + 1) % TICK_DIV;
                i_s_tick = (cnt == 0);
            end else begin
                i_s_tick = 1'b0;
            end
        end
    end

    // Output monitor: collects frames, checks pulse width, latency and data hold
    initial begin
        mon_data  = '0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (i_reset) begin
                mon_data = '0;
            end else if (o_rx_done) begin
                got_q.push_back({o_frame_err, o_data});
                chk("done_latency", 32'(i_s_tick), 32'(1));
                chk("done_width", 32'(prev_done), 32'(0));
                mon_data = o_data;
            end else begin
                chk("data_hold", 32'(o_data), 32'(mon_data));
                chk("err_alone", 32'(o_frame_err), 32'(0));
            end
            prev_done = o_rx_done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (i_s_tick !== 1'b1);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop);
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < int'(DATA_BITS); i++) begin
            i_rx = d[i];
            wait_ticks(16);
        end
        // A low stop bit is released early so the line is high before the next start
        i_rx = stop;
        wait_ticks(9);
        i_rx = 1'b1;
        wait_ticks(7);
    endtask

    task automatic check_frames(input string tag);
        logic [8:0] g;
        logic [8:0] e;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
            chk({tag, "_ferr"}, 32'(g[8]), 32'(e[8]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        bit         s;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", 32'(o_data), 32'(0));
        chk("reset_done", 32'(o_rx_done), 32'(0));
        chk("reset_ferr", 32'(o_frame_err), 32'(0));
        i_reset = 1'b0;
        wait_ticks(4);

        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h55, 1'b1);
        wait_ticks(4);
        check_frames("f55");

        exp_q.push_back({1'b0, 8'hA3});
        exp_q.push_back({1'b0, 8'h0F});
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_ticks(4);
        check_frames("b2b");

        i_rx = 1'b0;
        wait_ticks(3);
        i_rx = 1'b1;
        wait_ticks(20);
        check_frames("glitch");
        chk("glitch_data", 32'(o_data), 32'(8'h0F));

        exp_q.push_back({1'b1, 8'hC6});
        send_frame(8'hC6, 1'b0);
        wait_ticks(20);
        check_frames("ferr");

        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_ticks(16 + 16 * 4 + 8);
                i_reset = 1'b1;
                @(negedge clk);
                i_reset = 1'b0;
                chk("midreset_data", 32'(o_data), 32'(0));
                chk("midreset_done", 32'(o_rx_done), 32'(0));
                chk("midreset_ferr", 32'(o_frame_err), 32'(0));
            end
        join
        wait_ticks(4);
        check_frames("abort");
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1);
        wait_ticks(4);
        check_frames("after_rst");

        exp_q.push_back({1'b0, 8'h96});
        fork
            send_frame(8'h96, 1'b1);
            begin
                wait_ticks(16 + 16 * 3 + 5);
                tick_en = 1'b0;
                repeat (1000) @(negedge clk);
                chk("freeze_no_done", 32'(got_q.size()), 32'(0));
                chk("freeze_data", 32'(o_data), 32'(8'h3C));
                tick_en = 1'b1;
            end
        join
        wait_ticks(4);
        check_frames("freeze");

        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            exp_q.push_back({~s, d});
            send_frame(d, s);
            wait_ticks(20);
            check_frames("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
